// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer.
//   state_e   : FSM states (IDLE, SHIFT)
//   cnt_width : bits needed for a counter holding 0..n, i.e. ceil(log2(n+1))
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < (64'(n) + 64'd1)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: synchronous clear/increment, wraps to 0 after LAST.
//   clk_i   : clock (rising edge)
//   rst_ni  : synchronous active-low reset
//   clr_i   : force count to 0 (has priority over inc_i)
//   inc_i   : advance count by one, wrapping LAST -> 0
//   cnt_o   : current count
//   tc_o    : terminal count (cnt_o == LAST)
module piso_bit_counter #(
    parameter int unsigned CW   = 3,
    parameter int unsigned LAST = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o  = (cnt_q == CW'(LAST));
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready word handshake.
// A word is taken when IN_VALID && IN_READY at a rising edge; its bits then
// appear on SOUT one per cycle starting the next cycle, with SOUT_FIRST on
// the first bit and SOUT_LAST on the final bit. On the last bit a new word
// may be taken so frames run back to back.
//   CLK        : clock (rising edge)
//   RST        : synchronous active-low reset
//   IN         : parallel word
//   IN_VALID   : IN holds a word
//   IN_READY   : word accepted this cycle if IN_VALID
//   SOUT       : serial data
//   SOUT_VALID : SOUT carries a frame bit
//   SOUT_FIRST : first bit of frame
//   SOUT_LAST  : last bit of frame
// Build option: define PISO_PARITY_EN to append an even-parity bit
// (XOR of the data bits) to each frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             SOUT,
    output logic             SOUT_VALID,
    output logic             SOUT_FIRST,
    output logic             SOUT_LAST
);

`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned CW = cnt_width(WIDTH);

    state_e                 state_q, state_d;
    logic [FRAME_LEN-1:0]   shreg_q, shreg_d;
    logic [FRAME_LEN-1:0]   frame;
    logic [WIDTH-1:0]       ordered;
    logic [CW-1:0]          cnt;
    logic                   tc;
    logic                   last;
    logic                   ready;
    logic                   load;

    // The register always shifts toward its MSB, so the word is reordered
    // at load time to make the first frame bit land at the top.
    always_comb begin
        ordered = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ordered[i] = MSB_FIRST ? IN[i] : IN[WIDTH-1-i];
        end
    end

`ifdef PISO_PARITY_EN
    assign frame = {ordered, ^IN};
`else
    assign frame = ordered;
`endif

    assign last = (state_q == SHIFT) && tc;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
            end
            SHIFT: begin
                ready   = last;
                shreg_d = shreg_q << 1;
                if (last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!RST) begin
            ready = 1'b0;
        end
        load = IN_VALID && ready;
        if (load) begin
            state_d = SHIFT;
            shreg_d = frame;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

    piso_bit_counter #(
        .CW   (CW),
        .LAST (FRAME_LEN - 1)
    ) u_bit_counter (
        .clk_i  (CLK),
        .rst_ni (RST),
        .clr_i  (load),
        .inc_i  (state_q == SHIFT),
        .cnt_o  (cnt),
        .tc_o   (tc)
    );

    assign IN_READY   = ready;
    assign SOUT_VALID = (state_q == SHIFT);
    assign SOUT       = (state_q == SHIFT) && shreg_q[FRAME_LEN-1];
    assign SOUT_FIRST = (state_q == SHIFT) && (cnt == '0);
    assign SOUT_LAST  = last;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         IN_VALID = 1'b0;
    logic [W-1:0] IN = '0;

    logic m_rdy, m_s, m_v, m_f, m_l;
    logic l_rdy, l_s, l_v, l_f, l_l;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .CLK(CLK), .RST(RST), .IN(IN), .IN_VALID(IN_VALID), .IN_READY(m_rdy),
        .SOUT(m_s), .SOUT_VALID(m_v), .SOUT_FIRST(m_f), .SOUT_LAST(m_l)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .CLK(CLK), .RST(RST), .IN(IN), .IN_VALID(IN_VALID), .IN_READY(l_rdy),
        .SOUT(l_s), .SOUT_VALID(l_v), .SOUT_FIRST(l_f), .SOUT_LAST(l_l)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Output vectors are packed as {valid, sout, first, last, ready}.
    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got v,s,f,l,rdy=%b required %b", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model: queue of bits still to be shown
    typedef struct {
        bit b;
        bit fst;
        bit lst;
    } ebit_t;

    ebit_t mq[$];
    ebit_t lq[$];
    bit acc_m, acc_l;

    function automatic bit frame_bit(input logic [W-1:0] d, input bit msb, input int idx);
        if (idx == W) return ^d;
        return msb ? d[W-1-idx] : d[idx];
    endfunction

    always @(posedge CLK) begin
        acc_m = RST && IN_VALID && (mq.size() == 0 || mq[0].lst);
        acc_l = RST && IN_VALID && (lq.size() == 0 || lq[0].lst);
        if (!RST) begin
            mq.delete();
            lq.delete();
        end else begin
            if (mq.size() > 0) void'(mq.pop_front());
            if (lq.size() > 0) void'(lq.pop_front());
            if (acc_m)
                for (int i = 0; i < FL; i++)
                    mq.push_back('{b: frame_bit(IN, 1'b1, i), fst: (i == 0), lst: (i == FL - 1)});
            if (acc_l)
                for (int i = 0; i < FL; i++)
                    lq.push_back('{b: frame_bit(IN, 1'b0, i), fst: (i == 0), lst: (i == FL - 1)});
        end
    end

    logic [4:0] em, el;
    always @(negedge CLK) begin
        if (chk_en) begin
            if (mq.size() == 0) em = {4'b0000, RST};
            else em = {1'b1, mq[0].b, mq[0].fst, mq[0].lst, RST & mq[0].lst};
            if (lq.size() == 0) el = {4'b0000, RST};
            else el = {1'b1, lq[0].b, lq[0].fst, lq[0].lst, RST & lq[0].lst};
            check("model_msb", {m_v, m_s, m_f, m_l, m_rdy}, em);
            check("model_lsb", {l_v, l_s, l_f, l_l, l_rdy}, el);
        end
    end

    // ---------------- hand-computed literal expectations
`ifdef PISO_PARITY_EN
    // 1010 parity 0
    logic [4:0] t1_msb [FL] = '{5'b11100, 5'b10000, 5'b11000, 5'b10000, 5'b10011};
    logic [4:0] t1_lsb [FL] = '{5'b10100, 5'b11000, 5'b10000, 5'b11000, 5'b10011};
    // 1011 parity 1 -> 1,0,1,1,1
    logic [4:0] t6_msb [FL] = '{5'b11100, 5'b10000, 5'b11000, 5'b11000, 5'b11011};
`else
    logic [4:0] t1_msb [FL] = '{5'b11100, 5'b10000, 5'b11000, 5'b10011};
    logic [4:0] t1_lsb [FL] = '{5'b10100, 5'b11000, 5'b10000, 5'b11011};
    logic [4:0] t6_msb [FL] = '{5'b11100, 5'b10000, 5'b11000, 5'b11011};
    // 1010 then 0110 back to back -> 1,0,1,0,0,1,1,0
    logic [4:0] t3_msb [2*FL] = '{5'b11100, 5'b10000, 5'b11000, 5'b10011,
                                  5'b10100, 5'b11000, 5'b11000, 5'b10011};
`endif

    task automatic drive(input bit rst, input bit v, input logic [W-1:0] d);
        RST = rst;
        IN_VALID = v;
        IN = d;
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, '0);
        next();
        chk_en = 1'b1;
        @(negedge CLK);
        check("reset_held", {m_v, m_s, m_f, m_l, m_rdy}, 5'b00000);
        next();
        drive(1'b1, 1'b0, '0);
        @(negedge CLK);
        check("reset_released", {m_v, m_s, m_f, m_l, m_rdy}, 5'b00001);

        // single frame 1010, both bit orders
        drive(1'b1, 1'b1, 4'b1010);
        next();
        drive(1'b1, 1'b0, '0);
        for (int i = 0; i < FL; i++) begin
            @(negedge CLK);
            check("t1_msb_bit", {m_v, m_s, m_f, m_l, m_rdy}, t1_msb[i]);
            check("t1_lsb_bit", {l_v, l_s, l_f, l_l, l_rdy}, t1_lsb[i]);
            next();
        end
        @(negedge CLK);
        check("t1_idle_after", {m_v, m_s, m_f, m_l, m_rdy}, 5'b00001);

        // back to back 1010 then 0110 with IN_VALID held
        drive(1'b1, 1'b1, 4'b1010);
        next();
        drive(1'b1, 1'b1, 4'b0110);
        for (int i = 0; i < 2 * FL; i++) begin
            @(negedge CLK);
`ifndef PISO_PARITY_EN
            check("t3_b2b_bit", {m_v, m_s, m_f, m_l, m_rdy}, t3_msb[i]);
`endif
            next();
            if (i == FL - 1) drive(1'b1, 1'b0, '0);
        end
        @(negedge CLK);
        check("t3_idle_after", {m_v, m_s, m_f, m_l, m_rdy}, 5'b00001);

        // reset after the 2nd bit of 1100
        drive(1'b1, 1'b1, 4'b1100);
        next();
        drive(1'b1, 1'b0, '0);
        @(negedge CLK);
        check("t4_bit1", {m_v, m_s, m_f, m_l, m_rdy}, 5'b11100);
        next();
        drive(1'b0, 1'b1, 4'b1111);
        @(negedge CLK);
        check("t4_bit2_rst_low", {m_v, m_s, m_f, m_l, m_rdy}, 5'b11000);
        next();
        @(negedge CLK);
        check("t4_aborted", {m_v, m_s, m_f, m_l, m_rdy}, 5'b00000);
        next();
        drive(1'b1, 1'b0, '0);
        @(negedge CLK);
        check("t4_ready_after_rst", {m_v, m_s, m_f, m_l, m_rdy}, 5'b00001);
        next();
        @(negedge CLK);
        check("t4_no_leftover", {m_v, m_s, m_f, m_l, m_rdy}, 5'b00001);
        next();

        // 1111 offered in a non-last shift cycle is ignored
        drive(1'b1, 1'b1, 4'b1010);
        next();
        drive(1'b1, 1'b0, '0);
        for (int i = 0; i < FL; i++) begin
            @(negedge CLK);
            check("t5_frame_kept", {m_v, m_s, m_f, m_l, m_rdy}, t1_msb[i]);
            next();
            if (i == 0) drive(1'b1, 1'b1, 4'b1111);
            if (i == 1) drive(1'b1, 1'b0, '0);
        end
        @(negedge CLK);
        check("t5_idle_after", {m_v, m_s, m_f, m_l, m_rdy}, 5'b00001);

        // 1011 (with parity build: 1,0,1,1,1)
        drive(1'b1, 1'b1, 4'b1011);
        next();
        drive(1'b1, 1'b0, '0);
        for (int i = 0; i < FL; i++) begin
            @(negedge CLK);
            check("t6_frame_1011", {m_v, m_s, m_f, m_l, m_rdy}, t6_msb[i]);
            next();
        end

        // mixed valid pattern, checked by the model only
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, (i % 3) != 1, 4'((i * 7 + 3) % 16));
            next();
        end
        drive(1'b1, 1'b0, '0);
        for (int i = 0; i < FL + 2; i++) next();

        @(negedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
